// File: rtl/fe1_stage_t_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fe1_stage_t_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [XLEN-1:0]    DEF_RESET_VECTOR = 32'h0000_0000;
  localparam int unsigned        DEF_FB_DEPTH     = 2;
  localparam logic [INSTR_W-1:0] NOP              = 32'h0000_0013;

  // One fetched instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fe_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fe1_stage_t_if.sv
// Instruction-memory request/response channel between fetch and memory.
interface fe1_stage_t_if;
  import fe1_stage_t_pkg::*;

  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [XLEN-1:0]    imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/fe1_stage_t_fetch_buf.sv
// Circular FIFO of fetched entries; clear wins over push and pop.
module fe1_stage_t_fetch_buf
  import fe1_stage_t_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FB_DEPTH,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  fe_entry_t     din,
  output fe_entry_t     dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fe_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage write; a push into a full buffer reuses the slot being popped.
  always_ff @(posedge clk) begin
    if (do_push && !clear && !rst) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fe1_stage_t.sv
// Instruction-fetch stage: PC, credit-limited issue, response buffering, redirect.
module fe1_stage_t
  import fe1_stage_t_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter int unsigned     FB_DEPTH     = DEF_FB_DEPTH
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               ACT,
  input  logic               s_me1_pcsrc_D,
  input  logic [XLEN-1:0]    r_me1_target_Q,
  input  logic               id_stall,
  fe1_stage_t_if.master      imem,
  output logic               fe_valid,
  output logic [XLEN-1:0]    fe_pc,
  output logic [INSTR_W-1:0] fe_instr,
  output logic               fe_flush
);

  localparam int unsigned CW = $clog2(FB_DEPTH + 1);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fb_count;
  logic [CW:0]     credit_used;
  logic            issue;
  logic            redirect;
  logic            rsp_keep;
  logic            fb_pop;
  logic            fb_full;
  logic            fb_empty;
  logic [XLEN-1:0] tgt;
  fe_entry_t       fb_din;
  fe_entry_t       fb_head;
  fe_entry_t       hold;

  assign redirect    = s_me1_pcsrc_D;
  assign fe_flush    = s_me1_pcsrc_D;
  assign tgt         = word_align(r_me1_target_Q);
  assign credit_used = {1'b0, outstanding} + {1'b0, fb_count};

  assign imem.imem_req_valid = ~RST & ACT & ~redirect & (credit_used < (CW+1)'(FB_DEPTH));
  assign imem.imem_req_addr  = pc;
  assign issue               = imem.imem_req_valid & imem.imem_req_ready;

  assign rsp_keep = imem.imem_rsp_valid & (drop_cnt == '0) & ~redirect;
  assign fe_valid = ~fb_empty;
  assign fb_pop   = fe_valid & ~id_stall & ~redirect;
  assign fb_din   = '{pc: rsp_pc, instr: imem.imem_rsp_data};

  fe1_stage_t_fetch_buf #(.DEPTH(FB_DEPTH)) u_buf (
    .clk   (CLK),
    .rst   (RST),
    .push  (rsp_keep),
    .pop   (fb_pop),
    .clear (redirect),
    .din   (fb_din),
    .dout  (fb_head),
    .full  (fb_full),
    .empty (fb_empty),
    .count (fb_count)
  );

  // Show the head while non-empty, otherwise the last head that was shown.
  assign fe_pc    = fb_empty ? hold.pc    : fb_head.pc;
  assign fe_instr = fb_empty ? hold.instr : fb_head.instr;

  // Remember the most recently presented head for the empty case.
  always_ff @(posedge CLK) begin
    if (RST)            hold <= '0;
    else if (!fb_empty) hold <= fb_head;
  end

  // PC, response PC and in-flight/stale counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc          <= RESET_VECTOR;
      rsp_pc      <= RESET_VECTOR;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      case ({issue, imem.imem_rsp_valid})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: ;
      endcase
      if (redirect) begin
        pc       <= tgt;
        rsp_pc   <= tgt;
        // Everything still in flight is stale now, including ones already marked.
        drop_cnt <= outstanding - CW'(imem.imem_rsp_valid);
      end else begin
        if (issue) pc <= pc + XLEN'(4);
        if (imem.imem_rsp_valid) begin
          if (drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
          else                rsp_pc   <= rsp_pc + XLEN'(4);
        end
      end
    end
  end

  // Credit and stale-count invariants.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      assert (drop_cnt <= CW'(FB_DEPTH));
      assert (drop_cnt <= outstanding);
      assert (credit_used <= (CW+1)'(FB_DEPTH));
      assert (!(fb_full && rsp_keep && !fb_pop));
    end
  end

endmodule
